// File: rtl/mem_access_ctrl.sv
// M-stage memory sequencer: serialises up to two slot accesses of an issued pair onto one
// req/ack port, slot 1 first. Optional ack timeout is enabled by defining MEMCTL_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memtoregm,
    input  logic              memwritem,
    input  logic [ADDR_W-1:0] aluoutm,
    input  logic [DATA_W-1:0] writedatam,
    input  logic              memtoregm2,
    input  logic              memwritem2,
    input  logic [ADDR_W-1:0] aluoutm2,
    input  logic [DATA_W-1:0] writedatam2,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] readdatam,
    output logic [DATA_W-1:0] readdatam2,
    output logic              stallm,
    output logic              stallw,
    output logic              mem_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StDone} state_e;

    state_e state_q, state_d;

    logic need1, need2;
    logic write1, write2;
    logic load1, load2;
    logic abort;
    logic acc_done;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] readdata1_q, readdata1_d;
    logic [DATA_W-1:0] readdata2_q, readdata2_d;

    assign need1  = memtoregm | memwritem;
    assign need2  = memtoregm2 | memwritem2;
    assign write1 = memwritem;
    assign write2 = memwritem2;
    // A slot flagged as both load and store behaves as a store and captures nothing.
    assign load1  = memtoregm & ~memwritem;
    assign load2  = memtoregm2 & ~memwritem2;

`ifdef MEMCTL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q;
    logic            in_acc;

    assign in_acc = (state_q == StAcc1) || (state_q == StAcc2);
    assign abort  = in_acc && !mem_ack && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // Leaving ACCx (ack or abort) zeroes the count, so every access starts from 0.
    always_comb begin
        cnt_d = '0;
        if (in_acc && !mem_ack && !abort) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_err = err_q;
`else
    assign abort   = 1'b0;
    assign mem_err = 1'b0;
`endif

    assign acc_done = mem_ack | abort;
    assign cap_data = abort ? '0 : mem_rdata;

    always_comb begin
        state_d     = state_q;
        readdata1_d = readdata1_q;
        readdata2_d = readdata2_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        stallm      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (need1) begin
                    state_d = StAcc1;
                end else if (need2) begin
                    state_d = StAcc2;
                end
                stallm = need1 | need2;
            end
            StAcc1: begin
                mem_req   = 1'b1;
                mem_we    = write1;
                mem_addr  = aluoutm;
                mem_wdata = writedatam;
                stallm    = 1'b1;
                if (acc_done) begin
                    state_d = need2 ? StAcc2 : StDone;
                    if (load1) begin
                        readdata1_d = cap_data;
                    end
                end
            end
            StAcc2: begin
                mem_req   = 1'b1;
                mem_we    = write2;
                mem_addr  = aluoutm2;
                mem_wdata = writedatam2;
                stallm    = 1'b1;
                if (acc_done) begin
                    state_d = StDone;
                    if (load2) begin
                        readdata2_d = cap_data;
                    end
                end
            end
            StDone: begin
                // Stall drops here so the hazard controller advances the pair this cycle.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            readdata1_q <= '0;
            readdata2_q <= '0;
        end else begin
            state_q     <= state_d;
            readdata1_q <= readdata1_d;
            readdata2_q <= readdata2_d;
        end
    end

    assign readdatam  = readdata1_q;
    assign readdatam2 = readdata2_q;
    assign stallw     = stallm;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: drives M-stage pairs, answers the memory port from a
// small word model and checks stall/req lengths, ordering and load capture.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        memtoregm, memwritem, memtoregm2, memwritem2;
    logic [31:0] aluoutm, writedatam, aluoutm2, writedatam2;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] readdatam, readdatam2;
    logic        stallm, stallw, mem_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_model [256];
    int          n_stall, n_req;
    logic        first_we, unstable, done;

    mem_access_ctrl #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memtoregm  (memtoregm),
        .memwritem  (memwritem),
        .aluoutm    (aluoutm),
        .writedatam (writedatam),
        .memtoregm2 (memtoregm2),
        .memwritem2 (memwritem2),
        .aluoutm2   (aluoutm2),
        .writedatam2(writedatam2),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .readdatam  (readdatam),
        .readdatam2 (readdatam2),
        .stallm     (stallm),
        .stallw     (stallw),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        memtoregm  = 1'b0;
        memwritem  = 1'b0;
        memtoregm2 = 1'b0;
        memwritem2 = 1'b0;
        aluoutm    = '0;
        writedatam = '0;
        aluoutm2   = '0;
        writedatam2 = '0;
    endtask

    // Presents one pair at a negedge and services the port until the DONE cycle (stall low).
    // Ack comes after 'delay' wait cycles of each access; results land in module variables.
    task automatic run_pair(input logic l1, input logic w1, input logic [31:0] a1,
                            input logic [31:0] d1, input logic l2, input logic w2,
                            input logic [31:0] a2, input logic [31:0] d2, input int delay);
        int          waitc;
        logic [31:0] fa, fw;
        waitc    = 0;
        n_stall  = 0;
        n_req    = 0;
        first_we = 1'b0;
        unstable = 1'b0;
        done     = 1'b0;
        fa       = '0;
        fw       = '0;
        @(negedge clk);
        memtoregm  = l1;
        memwritem  = w1;
        aluoutm    = a1;
        writedatam = d1;
        memtoregm2 = l2;
        memwritem2 = w2;
        aluoutm2   = a2;
        writedatam2 = d2;
        mem_ack    = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            #1;
            if (!stallm) begin
                clear_inputs();
                mem_ack = 1'b0;
                done    = 1'b1;
                break;
            end
            n_stall++;
            if (mem_req) begin
                n_req++;
                if (waitc == 0) begin
                    fa = mem_addr;
                    fw = mem_wdata;
                    if (n_req == 1) first_we = mem_we;
                end else if (mem_addr !== fa || mem_wdata !== fw) begin
                    unstable = 1'b1;
                end
                if (waitc == delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_we ? 32'h0 : mem_model[mem_addr[7:0]];
                    if (mem_we) mem_model[mem_addr[7:0]] = mem_wdata;
                    waitc = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'h0;
                    waitc++;
                end
            end else begin
                mem_ack = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("pair_completed", {63'b0, done}, 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        mem_model[8'h10] = 32'hDEAD_BEEF;
        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        clear_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_req", {63'b0, mem_req}, 64'd0);
        check_eq("rst_stall", {62'b0, stallm, stallw}, 64'd0);
        check_eq("rst_rd1", {32'b0, readdatam}, 64'd0);
        check_eq("rst_rd2", {32'b0, readdatam2}, 64'd0);
        check_eq("rst_err", {63'b0, mem_err}, 64'd0);
        check_eq("rst_addr", {32'b0, mem_addr}, 64'd0);

        // Slot-1 load, zero-wait ack.
        run_pair(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        check_eq("ld1_stall", n_stall, 64'd2);
        check_eq("ld1_req", n_req, 64'd1);
        check_eq("ld1_we", {63'b0, first_we}, 64'd0);
        check_eq("ld1_rd1", {32'b0, readdatam}, 64'h0000_0000_DEAD_BEEF);
        check_eq("ld1_rd2", {32'b0, readdatam2}, 64'd0);

        // Slot-1 store then slot-2 load of the same address.
        run_pair(1'b0, 1'b1, 32'h20, 32'h1234, 1'b1, 1'b0, 32'h20, 32'h0, 0);
        check_eq("st_ld_stall", n_stall, 64'd3);
        check_eq("st_ld_req", n_req, 64'd2);
        check_eq("st_ld_we", {63'b0, first_we}, 64'd1);
        check_eq("st_ld_rd2", {32'b0, readdatam2}, 64'h1234);
        check_eq("st_ld_rd1", {32'b0, readdatam}, 64'h0000_0000_DEAD_BEEF);

        // Slot-2 store only, three wait cycles.
        run_pair(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h30, 32'hCAFE, 3);
        check_eq("st2_stall", n_stall, 64'd5);
        check_eq("st2_req", n_req, 64'd4);
        check_eq("st2_we", {63'b0, first_we}, 64'd1);
        check_eq("st2_stable", {63'b0, unstable}, 64'd0);
        check_eq("st2_mem", {32'b0, mem_model[8'h30]}, 64'hCAFE);

        // Empty pairs with spurious acks.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_ack   = 1'b1;
            mem_rdata = 32'h5A5A_0000 + 32'(i);
            #1;
            check_eq("idle_stall_req", {62'b0, stallm, mem_req}, 64'd0);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("idle_rd1", {32'b0, readdatam}, 64'h0000_0000_DEAD_BEEF);
        check_eq("idle_rd2", {32'b0, readdatam2}, 64'h1234);

        // Slot 1 with both load and store set acts as a store.
        run_pair(1'b1, 1'b1, 32'h50, 32'h77, 1'b0, 1'b0, 32'h0, 32'h0, 1);
        check_eq("ldst_stall", n_stall, 64'd3);
        check_eq("ldst_we", {63'b0, first_we}, 64'd1);
        check_eq("ldst_mem", {32'b0, mem_model[8'h50]}, 64'h77);
        check_eq("ldst_rd1", {32'b0, readdatam}, 64'h0000_0000_DEAD_BEEF);

`ifdef MEMCTL_TIMEOUT_EN
        // No ack ever: abort after TIMEOUT_CYCLES request cycles.
        run_pair(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1000);
        check_eq("to_req", n_req, 64'd8);
        check_eq("to_stall", n_stall, 64'd9);
        check_eq("to_rd1", {32'b0, readdatam}, 64'd0);
        check_eq("to_err", {63'b0, mem_err}, 64'd1);
        run_pair(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        check_eq("to_err_sticky", {63'b0, mem_err}, 64'd1);
`else
        check_eq("no_to_err", {63'b0, mem_err}, 64'd0);
        run_pair(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
`endif
        check_eq("reload_rd1", {32'b0, readdatam}, 64'h0000_0000_DEAD_BEEF);

        // Reset in the second wait cycle of ACC1; a later ack must not capture.
        @(negedge clk);
        memtoregm = 1'b1;
        aluoutm   = 32'h10;
        mem_ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_mid_req", {63'b0, mem_req}, 64'd1);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_mid_req_drop", {63'b0, mem_req}, 64'd0);
        check_eq("rst_mid_stall", {63'b0, stallm}, 64'd0);
        check_eq("rst_mid_rd1", {32'b0, readdatam}, 64'd0);
        check_eq("rst_mid_rd2", {32'b0, readdatam2}, 64'd0);
        check_eq("rst_mid_err", {63'b0, mem_err}, 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check_eq("late_ack_rd1", {32'b0, readdatam}, 64'd0);
        check_eq("late_ack_req", {63'b0, mem_req}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
